// File: rtl/alu_result_stage.sv
// Writeback stage behind the 16-bit ALU adder: buffers sum+flags in a small FIFO
// and tracks the committed processor status word, sticky overflow and commit count.
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_z,
    input  logic              in_sign,
    input  logic              in_zero,
    input  logic              in_carry,
    input  logic              in_parity,
    input  logic              in_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_z,
    output logic [4:0]        out_flags,
    output logic [4:0]        psw,
    output logic              sticky_ovf,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  commit_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DATA_W-1:0] z_mem    [DEPTH];
    logic [4:0]        flag_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              push;
    logic              pop;

    // Both handshake qualifiers come purely from the registered occupancy.
    assign in_ready  = (occ != FULL_OCC);
    assign out_valid = (occ != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_z     = z_mem[rd_ptr];
    assign out_flags = flag_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            z_mem[wr_ptr]    <= in_z;
            flag_mem[wr_ptr] <= {in_overflow, in_parity, in_carry, in_zero, in_sign};
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Commit side effects; a committed overflow takes priority over a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psw        <= '0;
            sticky_ovf <= 1'b0;
            commit_cnt <= '0;
        end else begin
            if (pop) begin
                psw <= out_flags;
                if (commit_cnt != '1) begin
                    commit_cnt <= commit_cnt + CNT_W'(1);
                end
            end
            if (pop && out_flags[4]) begin
                sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: stimulus queues expected results computed
// from operand arithmetic, a negedge monitor compares commits and status state.
module tb_alu_result_stage;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 2;
    // Narrow counter so saturation is reachable within a short run.
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [15:0] z;
        logic [4:0]  flags;
    } item_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_z;
    logic              in_sign;
    logic              in_zero;
    logic              in_carry;
    logic              in_parity;
    logic              in_overflow;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_z;
    logic [4:0]        out_flags;
    logic [4:0]        psw;
    logic              sticky_ovf;
    logic              clr_sticky;
    logic [CNT_W-1:0]  commit_cnt;

    item_t exp_q[$];
    item_t mon_item;
    int    checks = 0;
    int    errors = 0;
    int    occ_m;
    int    cnt_m;
    logic [4:0] psw_m;
    logic  sticky_m;
    logic  push_m;
    logic  pop_m;
    bit    done;

    alu_result_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
        .in_sign(in_sign), .in_zero(in_zero), .in_carry(in_carry),
        .in_parity(in_parity), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_flags(out_flags),
        .psw(psw), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
        .commit_cnt(commit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected result of the adder from plain integer arithmetic on the operands.
    function automatic item_t refModel(input logic [15:0] a, input logic [15:0] b);
        item_t r;
        int unsigned usum;
        int ssum;
        usum = int'(a) + int'(b);
        ssum = int'($signed(a)) + int'($signed(b));
        r.z = usum[15:0];
        r.flags = {(ssum > 32767) || (ssum < -32768),
                   ($countones(r.z) % 2) == 0,
                   usum > 32'd65535,
                   r.z == 16'd0,
                   r.z >= 16'h8000};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one result and hold it until accepted; returns just after the push edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        item_t it;
        int waited;
        it = refModel(a, b);
        waited = 0;
        in_valid = 1'b1;
        in_z = it.z;
        {in_overflow, in_parity, in_carry, in_zero, in_sign} = it.flags;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (in_ready) begin
            exp_q.push_back(it);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: checks handshake and status state each cycle, scoreboard on each commit.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                occ_m    = 0;
                cnt_m    = 0;
                psw_m    = '0;
                sticky_m = 1'b0;
            end else begin
                checkOutput("in_ready", in_ready, occ_m < DEPTH);
                checkOutput("out_valid", out_valid, occ_m != 0);
                checkOutput("psw", psw, psw_m);
                checkOutput("sticky_ovf", sticky_ovf, sticky_m);
                checkOutput("commit_cnt", commit_cnt, cnt_m);
                push_m = in_valid && (occ_m < DEPTH);
                pop_m  = out_ready && (occ_m != 0);
                if (pop_m) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL scoreboard: got commit expected none queued");
                    end else begin
                        mon_item = exp_q.pop_front();
                        checkOutput("out_z", out_z, mon_item.z);
                        checkOutput("out_flags", out_flags, mon_item.flags);
                        psw_m = mon_item.flags;
                        if (mon_item.flags[4]) begin
                            sticky_m = 1'b1;
                        end else if (clr_sticky) begin
                            sticky_m = 1'b0;
                        end
                        if (cnt_m < CNT_MAX) begin
                            cnt_m++;
                        end
                    end
                end else if (clr_sticky) begin
                    sticky_m = 1'b0;
                end
                occ_m = occ_m + int'(push_m) - int'(pop_m);
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_z = '0;
        {in_overflow, in_parity, in_carry, in_zero, in_sign} = '0;
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");

        // Single overflowing result.
        out_ready = 1'b1;
        applyStimulus(16'h7FFF, 16'h0001);
        checkOutput("t1_out_valid", out_valid, 1);
        checkOutput("t1_out_z", out_z, 16'h8000);
        checkOutput("t1_out_flags", out_flags, 5'b10001);
        @(posedge clk);
        #1;
        checkOutput("t1_psw", psw, 5'b10001);
        checkOutput("t1_sticky", sticky_ovf, 1);
        checkOutput("t1_cnt", commit_cnt, 1);

        // Zero/carry result leaves sticky untouched.
        applyStimulus(16'hFFFF, 16'h0001);
        checkOutput("t2_out_flags", out_flags, 5'b01110);
        @(posedge clk);
        #1;
        checkOutput("t2_psw", psw, 5'b01110);
        checkOutput("t2_sticky", sticky_ovf, 1);

        // Fill with backpressure, then drain.
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(16'h0001, 16'h0000);
                applyStimulus(16'h0002, 16'h0000);
                applyStimulus(16'h0003, 16'h0000);
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                checkOutput("t3_full_in_ready", in_ready, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Sticky set wins over clear; clear alone then takes effect.
        out_ready = 1'b0;
        applyStimulus(16'h4000, 16'h4000);
        clr_sticky = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t4_set_wins", sticky_ovf, 1);
        @(posedge clk);
        #1;
        checkOutput("t4_clear", sticky_ovf, 0);
        clr_sticky = 1'b0;

        // Asynchronous reset with two entries buffered.
        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h0000);
        applyStimulus(16'h2222, 16'h0000);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_in_ready", in_ready, 1);
        checkOutput("t5_psw", psw, 0);
        checkOutput("t5_cnt", commit_cnt, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Steady streaming of 20 results.
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(16'(k), 16'h0000);
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6_cnt", commit_cnt, 20);

        // Random traffic with random backpressure and clears; drives counter into saturation.
        fork
            begin
                repeat (80) begin
                    applyStimulus(16'($urandom), 16'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    clr_sticky = ($urandom_range(0, 7) == 0);
                end
            end
        join
        out_ready = 1'b1;
        clr_sticky = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t7_saturated", commit_cnt, CNT_MAX);
        checkOutput("t7_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered writeback stage directly downstream of the 16-bit ALU adder.
- Captures the combinational sum and its five status flags (sign, zero, carry, parity, overflow) through a valid/ready handshake into a small FIFO buffer.
- Presents results in order to the register-file/consumer side.
- On each committed result, updates an architectural processor status word (PSW), a sticky overflow flag and a saturating commit counter.

Parameters:
- DATA_W, 16, width of the sum word from the adder.
- DEPTH, 2, buffer entries; power of two, legal range 2..16.
- CNT_W, 16, width of the saturating commit counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; equals (occupancy < DEPTH), driven from registered state only.
- in_z  input  DATA_W  sum from adder.
- in_sign  input  1  sum MSB.
- in_zero  input  1  sum == 0.
- in_carry  input  1  carry out of last stage.
- in_parity  input  1  1 = even number of ones in sum.
- in_overflow  input  1  signed overflow.
- out_valid  output  1  head entry valid (occupancy != 0).
- out_ready  input  1  consumer accepts head entry.
- out_z  output  DATA_W  head entry sum.
- out_flags  output  5  head entry flags {overflow,parity,carry,zero,sign}.
- psw  output  5  last committed flags, same packing.
- sticky_ovf  output  1  set by any committed overflow.
- clr_sticky  input  1  synchronous clear of sticky_ovf.
- commit_cnt  output  CNT_W  saturating count of committed results.

Behaviour:
- Handshakes:
  - Push occurs when in_valid & in_ready.
  - Pop (commit) occurs when out_valid & out_ready.
  - Both are evaluated on the same rising clk edge.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and occupancy counter (0..DEPTH).
  - Pointers wrap modulo DEPTH.
  - Strict in-order delivery; no bypass, so minimum latency is 1 cycle from push to out_valid.
- Simultaneous push and pop:
  - Occupancy unchanged; both pointers advance.
  - At occupancy == DEPTH, in_ready is 0, so only the pop occurs that cycle; in_ready rises the next cycle.
  - At occupancy == 0, out_valid is 0, so only the push occurs.
- Data rules:
  - out_z and out_flags reflect the entry at rd_ptr and are stable while out_valid & ~out_ready.
  - Undefined contents when empty; the bench must not check them.
  - in_* payload is sampled only on push. in_valid without in_ready is dropped by the upstream convention: upstream must hold its payload until accepted.
- Commit side effects (on pop only, same edge):
  - psw <= popped flags.
  - If the popped overflow flag is 1, sticky_ovf <= 1.
  - Else if clr_sticky, sticky_ovf <= 0. Set wins over a simultaneous clear.
  - commit_cnt <= commit_cnt + 1, saturating at all-ones (no wrap).
- Without a pop, clr_sticky alone clears sticky_ovf on the next edge; psw and commit_cnt hold.
- Reset (asynchronous, any time including mid-transfer):
  - occupancy = 0, wr_ptr = rd_ptr = 0.
  - in_ready = 1 and out_valid = 0 as soon as rst asserts.
  - psw = 5'b00000, sticky_ovf = 0, commit_cnt = 0.
  - In-flight entries are discarded.
  - First push is permitted on the first rising edge after rst deasserts.
- State view: EMPTY (occ = 0), PARTIAL (0 < occ < DEPTH), FULL (occ = DEPTH). Transitions follow push/pop as above; there is no other control state.

Test Plan:
- Single result: push z=0x8000 with flags {ovf=1,par=0,car=0,zero=0,sign=1} (0x7FFF+0x0001); out_ready=1.
  - Required: out_valid one cycle later with out_z=0x8000, out_flags=5'b10001.
  - After the pop: psw=5'b10001, sticky_ovf=1, commit_cnt=1.
- Fill and backpressure: out_ready=0; push 0x0001, 0x0002, 0x0003 on consecutive cycles.
  - Required: first two accepted, in_ready=0 on the third, which is held upstream.
  - Raising out_ready drains 0x0001, 0x0002, 0x0003 in order; in_ready returns to 1 one cycle after the first pop.
- Steady streaming: in_valid=out_ready=1 for 20 cycles with z=k.
  - Required: occupancy holds at 1, one commit per cycle, commit_cnt=20, outputs in order.
- Zero/carry case: push z=0x0000, flags {0,1,1,1,0} (0xFFFF+0x0001).
  - Required: out_flags=5'b01110 and psw=5'b01110 after the pop.
  - sticky_ovf is unchanged from its prior value.
- Sticky set-vs-clear: pop an entry with ovf=1 while clr_sticky=1.
  - Required: sticky_ovf=1.
  - Next cycle, clr_sticky=1 with no pop: sticky_ovf=0.
- Reset mid-operation: two entries buffered, assert rst between edges.
  - Required: out_valid=0, in_ready=1, psw=0, commit_cnt=0 immediately.
  - Preload commit_cnt=0xFFFF and pop once: stays 0xFFFF.
